// File: rtl/pkg_vid_seq.sv
// Shared types and widths for the video frame sequencer.
// The configuration record is sized by the package widths used as the top-level defaults.
package pkg_vid_seq;

  localparam int SEQ_DATA_WIDTH = 8;
  localparam int SEQ_H_WIDTH    = 12;
  localparam int SEQ_V_WIDTH    = 12;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    VBP  = 3'd1,
    ACT  = 3'd2,
    VFP  = 3'd3,
    DONE = 3'd4
  } e_seq_state;

  typedef struct packed {
    logic [SEQ_H_WIDTH-1:0] hbp;
    logic [SEQ_H_WIDTH-1:0] hact;
    logic [SEQ_H_WIDTH-1:0] hfp;
    logic [SEQ_V_WIDTH-1:0] vbp;
    logic [SEQ_V_WIDTH-1:0] vact;
    logic [SEQ_V_WIDTH-1:0] vfp;
  } st_vid_cfg;

  function automatic logic in_frame(input e_seq_state s);
    return s inside {VBP, ACT, VFP};
  endfunction

endpackage

// File: rtl/vid_line_counter.sv
// Horizontal/vertical position counters for one frame, with end-of-line and end-of-frame strobes.
// The *_nxt outputs expose the next-cycle position so the top can register sync outputs without extra lag.
module vid_line_counter #(
  parameter int HC_W = 14,
  parameter int VC_W = 14
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            clr_i,
  input  logic            run_i,
  input  logic [HC_W-1:0] line_len_i,
  input  logic [VC_W-1:0] frame_lines_i,
  output logic [HC_W-1:0] hcnt_o,
  output logic [VC_W-1:0] vcnt_o,
  output logic [HC_W-1:0] hcnt_nxt_o,
  output logic [VC_W-1:0] vcnt_nxt_o,
  output logic            eol_o,
  output logic            eof_o
);

  logic [HC_W-1:0] hcnt_q, hcnt_d;
  logic [VC_W-1:0] vcnt_q, vcnt_d;

  assign eol_o = run_i && (hcnt_q == line_len_i - HC_W'(1));
  assign eof_o = eol_o && (vcnt_q == frame_lines_i - VC_W'(1));

  // NOTE: every signal assigned in always_comb gets a default first; a missing branch would infer a latch.
  always_comb begin
    hcnt_d = hcnt_q;
    vcnt_d = vcnt_q;
    if (clr_i) begin
      hcnt_d = '0;
      vcnt_d = '0;
    end else if (run_i) begin
      if (eol_o) begin
        hcnt_d = '0;
        vcnt_d = eof_o ? '0 : vcnt_q + VC_W'(1);
      end else begin
        hcnt_d = hcnt_q + HC_W'(1);
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      hcnt_q <= '0;
      vcnt_q <= '0;
    end else begin
      hcnt_q <= hcnt_d;
      vcnt_q <= vcnt_d;
    end
  end

  assign hcnt_o     = hcnt_q;
  assign vcnt_o     = vcnt_q;
  assign hcnt_nxt_o = hcnt_d;
  assign vcnt_nxt_o = vcnt_d;

endmodule

// File: rtl/vid_frame_sequencer.sv
// Frame timing controller: sequences one frame of vs/hs/de per start, pulling pixels via valid/ready.
// Holds the FSM, the config latch and the registered output stage.
module vid_frame_sequencer
  import pkg_vid_seq::*;
#(
  parameter int DATA_WIDTH = SEQ_DATA_WIDTH,
  parameter int H_WIDTH    = SEQ_H_WIDTH,
  parameter int V_WIDTH    = SEQ_V_WIDTH
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  i_start,
  input  logic                  i_abort,
  input  logic [H_WIDTH-1:0]    i_hbp,
  input  logic [H_WIDTH-1:0]    i_hact,
  input  logic [H_WIDTH-1:0]    i_hfp,
  input  logic [V_WIDTH-1:0]    i_vbp,
  input  logic [V_WIDTH-1:0]    i_vact,
  input  logic [V_WIDTH-1:0]    i_vfp,
  input  logic                  i_pix_valid,
  input  logic [DATA_WIDTH-1:0] i_pix_r,
  input  logic [DATA_WIDTH-1:0] i_pix_g,
  input  logic [DATA_WIDTH-1:0] i_pix_b,
  output logic                  o_pix_ready,
  output logic                  o_vs,
  output logic                  o_hs,
  output logic                  o_de,
  output logic [DATA_WIDTH-1:0] o_r,
  output logic [DATA_WIDTH-1:0] o_g,
  output logic [DATA_WIDTH-1:0] o_b,
  output logic                  o_busy,
  output logic                  o_frame_done,
  output logic                  o_cfg_err,
  output logic                  o_underflow
);

  // A three-term size sum needs two extra bits to be overflow-free.
  localparam int HS_W = H_WIDTH + 2;
  localparam int VS_W = V_WIDTH + 2;

  e_seq_state state_q, state_d;
  st_vid_cfg  cfg_q;

  logic [HS_W-1:0] line_len, pix_lo, pix_hi, hcnt, hcnt_nxt;
  logic [VS_W-1:0] frame_lines, act_end, vcnt, vcnt_nxt, vcnt_inc;
  logic            eol, eof;
  logic            start_req, start_ok, cfg_bad, abort_hit;
  logic            pix_ready, pix_take;

  logic                  vs_q, hs_q, de_q, busy_q, done_q, cfg_err_q, underflow_q;
  logic [DATA_WIDTH-1:0] r_q, g_q, b_q;

  assign line_len    = HS_W'(cfg_q.hbp) + HS_W'(cfg_q.hact) + HS_W'(cfg_q.hfp);
  assign pix_lo      = HS_W'(cfg_q.hbp);
  assign pix_hi      = HS_W'(cfg_q.hbp) + HS_W'(cfg_q.hact);
  assign frame_lines = VS_W'(cfg_q.vbp) + VS_W'(cfg_q.vact) + VS_W'(cfg_q.vfp);
  assign act_end     = VS_W'(cfg_q.vbp) + VS_W'(cfg_q.vact);
  assign vcnt_inc    = vcnt + VS_W'(1);

  vid_line_counter #(
    .HC_W (HS_W),
    .VC_W (VS_W)
  ) u_line_counter (
    .clk           (clk),
    .rstn          (rstn),
    .clr_i         (!in_frame(state_d)),
    .run_i         (in_frame(state_q)),
    .line_len_i    (line_len),
    .frame_lines_i (frame_lines),
    .hcnt_o        (hcnt),
    .vcnt_o        (vcnt),
    .hcnt_nxt_o    (hcnt_nxt),
    .vcnt_nxt_o    (vcnt_nxt),
    .eol_o         (eol),
    .eof_o         (eof)
  );

  // Abort outranks start, so a simultaneous pair in IDLE drops the start.
  assign start_req = (state_q == IDLE) && i_start && !i_abort;
  assign cfg_bad   = (i_hact == '0) || (i_vact == '0);
  assign start_ok  = start_req && !cfg_bad;
  assign abort_hit = i_abort && (state_q != IDLE);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (start_ok) state_d = (i_vbp != '0) ? VBP : ACT;
      VBP:  if (eol && vcnt_inc == VS_W'(cfg_q.vbp)) state_d = ACT;
      ACT: begin
        if (eof)                              state_d = DONE;
        else if (eol && vcnt_inc == act_end)  state_d = VFP;
      end
      VFP:  if (eof) state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (abort_hit) state_d = IDLE;
  end

  assign pix_ready = (state_q == ACT) && (hcnt >= pix_lo) && (hcnt < pix_hi);
  assign pix_take  = pix_ready && i_pix_valid && !abort_hit;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      cfg_q   <= '0;
    end else begin
      state_q <= state_d;
      if (start_ok) begin
        cfg_q.hbp  <= i_hbp;
        cfg_q.hact <= i_hact;
        cfg_q.hfp  <= i_hfp;
        cfg_q.vbp  <= i_vbp;
        cfg_q.vact <= i_vact;
        cfg_q.vfp  <= i_vfp;
      end
    end
  end

  // Sync outputs come from the next-cycle position so they line up with o_busy;
  // o_de and pixel data follow the handshake one cycle behind it.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      vs_q        <= 1'b0;
      hs_q        <= 1'b0;
      de_q        <= 1'b0;
      r_q         <= '0;
      g_q         <= '0;
      b_q         <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      cfg_err_q   <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      vs_q      <= in_frame(state_d) && (vcnt_nxt == '0);
      hs_q      <= in_frame(state_d) && (hcnt_nxt == '0);
      de_q      <= pix_ready && !abort_hit;
      r_q       <= pix_take ? i_pix_r : '0;
      g_q       <= pix_take ? i_pix_g : '0;
      b_q       <= pix_take ? i_pix_b : '0;
      busy_q    <= (state_d != IDLE);
      done_q    <= (state_d == DONE);
      cfg_err_q <= start_req && cfg_bad;
      if (start_ok)                       underflow_q <= 1'b0;
      else if (pix_ready && !i_pix_valid) underflow_q <= 1'b1;
    end
  end

  assign o_pix_ready  = pix_ready;
  assign o_vs         = vs_q;
  assign o_hs         = hs_q;
  assign o_de         = de_q;
  assign o_r          = r_q;
  assign o_g          = g_q;
  assign o_b          = b_q;
  assign o_busy       = busy_q;
  assign o_frame_done = done_q;
  assign o_cfg_err    = cfg_err_q;
  assign o_underflow  = underflow_q;

endmodule

// File: tb/tb_vid_frame_sequencer.sv
// Randomized self-checking bench for vid_frame_sequencer against a frame-position reference model.
// The model tracks the frame as a flat cycle index and derives line/pixel position by division.
module tb_vid_frame_sequencer;

  localparam int DW = 8;
  localparam int HW = 12;
  localparam int VW = 12;

  logic          clk = 1'b0;
  logic          rstn;
  logic          i_start, i_abort, i_pix_valid;
  logic [HW-1:0] i_hbp, i_hact, i_hfp;
  logic [VW-1:0] i_vbp, i_vact, i_vfp;
  logic [DW-1:0] i_pix_r, i_pix_g, i_pix_b;
  logic          o_pix_ready, o_vs, o_hs, o_de, o_busy, o_frame_done, o_cfg_err, o_underflow;
  logic [DW-1:0] o_r, o_g, o_b;

  always #5 clk = ~clk;

  vid_frame_sequencer #(
    .DATA_WIDTH (DW),
    .H_WIDTH    (HW),
    .V_WIDTH    (VW)
  ) dut (
    .clk          (clk),
    .rstn         (rstn),
    .i_start      (i_start),
    .i_abort      (i_abort),
    .i_hbp        (i_hbp),
    .i_hact       (i_hact),
    .i_hfp        (i_hfp),
    .i_vbp        (i_vbp),
    .i_vact       (i_vact),
    .i_vfp        (i_vfp),
    .i_pix_valid  (i_pix_valid),
    .i_pix_r      (i_pix_r),
    .i_pix_g      (i_pix_g),
    .i_pix_b      (i_pix_b),
    .o_pix_ready  (o_pix_ready),
    .o_vs         (o_vs),
    .o_hs         (o_hs),
    .o_de         (o_de),
    .o_r          (o_r),
    .o_g          (o_g),
    .o_b          (o_b),
    .o_busy       (o_busy),
    .o_frame_done (o_frame_done),
    .o_cfg_err    (o_cfg_err),
    .o_underflow  (o_underflow)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: phase 0 idle, 1 in frame (m_pos = cycles since frame start), 2 done cycle.
  int m_phase, m_pos, m_len, m_total;
  int m_hbp, m_hact, m_vbp, m_vact;
  bit e_busy, e_hs, e_vs, e_de, e_done, e_err, e_uf;
  int e_r, e_g, e_b;

  int cyc = 0;
  int n_hs, n_vs, n_de, done_cyc;

  task automatic model_reset();
    m_phase = 0; m_pos = 0; m_len = 0; m_total = 0;
    m_hbp = 0; m_hact = 0; m_vbp = 0; m_vact = 0;
    e_busy = 0; e_hs = 0; e_vs = 0; e_de = 0; e_done = 0; e_err = 0; e_uf = 0;
    e_r = 0; e_g = 0; e_b = 0;
  endtask

  function automatic bit m_active(input int pos);
    int h, v;
    if (m_phase != 1) return 1'b0;
    h = pos % m_len;
    v = pos / m_len;
    return (v >= m_vbp) && (v < m_vbp + m_vact) && (h >= m_hbp) && (h < m_hbp + m_hact);
  endfunction

  task automatic model_step();
    bit rdy, abort_eff, start_ok, start_bad;
    int np, npos;
    rdy       = m_active(m_pos);
    abort_eff = i_abort && (m_phase != 0);
    start_ok  = (m_phase == 0) && i_start && !i_abort && (i_hact != 0) && (i_vact != 0);
    start_bad = (m_phase == 0) && i_start && !i_abort && ((i_hact == 0) || (i_vact == 0));
    e_de = rdy && !abort_eff;
    if (rdy && i_pix_valid && !abort_eff) begin
      e_r = int'(i_pix_r); e_g = int'(i_pix_g); e_b = int'(i_pix_b);
    end else begin
      e_r = 0; e_g = 0; e_b = 0;
    end
    if (start_ok)                  e_uf = 1'b0;
    else if (rdy && !i_pix_valid)  e_uf = 1'b1;
    e_err = start_bad;
    np = m_phase;
    npos = m_pos;
    if (abort_eff) begin
      np = 0; npos = 0;
    end else if (start_ok) begin
      m_hbp   = int'(i_hbp);
      m_hact  = int'(i_hact);
      m_vbp   = int'(i_vbp);
      m_vact  = int'(i_vact);
      m_len   = int'(i_hbp) + int'(i_hact) + int'(i_hfp);
      m_total = m_len * (int'(i_vbp) + int'(i_vact) + int'(i_vfp));
      np = 1; npos = 0;
    end else if (m_phase == 1) begin
      if (m_pos == m_total - 1) begin np = 2; npos = 0; end
      else npos = m_pos + 1;
    end else if (m_phase == 2) begin
      np = 0;
    end
    m_phase = np;
    m_pos   = npos;
    e_busy  = (np != 0);
    e_done  = (np == 2);
    e_hs    = 1'b0;
    e_vs    = 1'b0;
    if (np == 1) begin
      e_hs = (npos % m_len) == 0;
      e_vs = npos < m_len;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    check("busy",       o_busy,       e_busy);
    check("hs",         o_hs,         e_hs);
    check("vs",         o_vs,         e_vs);
    check("de",         o_de,         e_de);
    check("r",          o_r,          e_r);
    check("g",          o_g,          e_g);
    check("b",          o_b,          e_b);
    check("frame_done", o_frame_done, e_done);
    check("cfg_err",    o_cfg_err,    e_err);
    check("underflow",  o_underflow,  e_uf);
    check("pix_ready",  o_pix_ready,  m_active(m_pos));
    if (o_hs) n_hs++;
    if (o_vs) n_vs++;
    if (o_de) n_de++;
    if (o_frame_done) done_cyc = cyc;
    model_step();
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic set_cfg(input int hbp, hact, hfp, vbp, vact, vfp);
    i_hbp = HW'(hbp); i_hact = HW'(hact); i_hfp = HW'(hfp);
    i_vbp = VW'(vbp); i_vact = VW'(vact); i_vfp = VW'(vfp);
  endtask

  // mode 0: always valid, ramp data; 1: random valid and data; 2: ramp, valid dropped at frame cycle drop_pos
  task automatic drive_pix(input int mode, input int drop_pos);
    if (mode == 1) begin
      i_pix_valid = ($urandom_range(0, 3) != 0);
      i_pix_r = DW'($urandom); i_pix_g = DW'($urandom); i_pix_b = DW'($urandom);
    end else begin
      i_pix_valid = !(mode == 2 && m_phase == 1 && m_pos == drop_pos);
      i_pix_r = DW'(cyc); i_pix_g = DW'(cyc * 3); i_pix_b = DW'(~cyc);
    end
  endtask

  task automatic run_frame(input int mode, input int drop_pos, input int abort_at,
                           input int restart_at, input bit chaos);
    int tail;
    tail = 0;
    n_hs = 0; n_vs = 0; n_de = 0; done_cyc = -1;
    drive_pix(mode, drop_pos);
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    for (int i = 1; i < 400; i++) begin
      tail = (m_phase == 0) ? tail + 1 : 0;
      if (tail > 2) break;
      drive_pix(mode, drop_pos);
      i_abort = (i == abort_at) || (chaos && $urandom_range(0, 99) == 0);
      i_start = (i == restart_at) || (chaos && m_phase != 0 && $urandom_range(0, 9) == 0);
      if (chaos)
        set_cfg($urandom_range(0, 5), $urandom_range(0, 5), $urandom_range(0, 5),
                $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
      tick();
      i_abort = 1'b0;
      i_start = 1'b0;
    end
    check("idle_after_frame", o_busy, 1'b0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, o_busy, 0);
    check({tag, "_hs"},   o_hs,   0);
    check({tag, "_vs"},   o_vs,   0);
    check({tag, "_de"},   o_de,   0);
    check({tag, "_rgb"},  {8'h0, o_r, o_g, o_b}, 0);
    check({tag, "_done"}, o_frame_done, 0);
    check({tag, "_err"},  o_cfg_err, 0);
    check({tag, "_uf"},   o_underflow, 0);
    check({tag, "_rdy"},  o_pix_ready, 0);
  endtask

  int start_cyc;

  initial begin
    rstn = 1'b0;
    i_start = 1'b0; i_abort = 1'b0; i_pix_valid = 1'b0;
    i_pix_r = '0; i_pix_g = '0; i_pix_b = '0;
    set_cfg(0, 0, 0, 0, 0, 0);
    model_reset();
    #12;
    check_all_zero("reset");
    @(posedge clk);
    #1;
    rstn = 1'b1;
    repeat (3) tick();

    // Scenario 1: 8 lines of 10 cycles, continuous pixels
    set_cfg(3, 4, 3, 3, 2, 3);
    start_cyc = cyc;
    run_frame(0, -1, -1, -1, 1'b0);
    check("s1_hs_pulses", n_hs, 8);
    check("s1_vs_cycles", n_vs, 10);
    check("s1_de_cycles", n_de, 8);
    check("s1_done_offset", done_cyc - start_cyc, 81);

    // Scenario 2: minimal frame
    set_cfg(0, 1, 0, 0, 1, 0);
    start_cyc = cyc;
    run_frame(0, -1, -1, -1, 1'b0);
    check("s2_hs_pulses", n_hs, 1);
    check("s2_de_cycles", n_de, 1);
    check("s2_done_offset", done_cyc - start_cyc, 2);

    // Scenario 3: valid dropped for pixel 2 of line 3 (frame cycle 35)
    set_cfg(3, 4, 3, 3, 2, 3);
    run_frame(2, 35, -1, -1, 1'b0);
    check("s3_de_cycles", n_de, 8);
    check("s3_underflow_sticky", o_underflow, 1);

    // Scenario 4: abort at frame cycle 25, then a frame with an ignored second start
    run_frame(0, -1, 25, -1, 1'b0);
    check("s4_no_done", done_cyc, -1);
    start_cyc = cyc;
    run_frame(0, -1, -1, 30, 1'b0);
    check("s4_restart_ignored", done_cyc - start_cyc, 81);

    // Scenario 5: rejected configurations and abort colliding with start in idle
    set_cfg(2, 0, 2, 1, 2, 1);
    run_frame(0, -1, -1, -1, 1'b0);
    set_cfg(2, 3, 2, 1, 0, 1);
    run_frame(0, -1, -1, -1, 1'b0);
    set_cfg(1, 2, 1, 1, 1, 1);
    i_start = 1'b1; i_abort = 1'b1;
    tick();
    i_start = 1'b0; i_abort = 1'b0;
    repeat (3) tick();

    // Randomized frames with mid-frame config noise, start spam and occasional aborts
    for (int f = 0; f < 30; f++) begin
      set_cfg($urandom_range(0, 3),
              ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 5),
              $urandom_range(0, 3), $urandom_range(0, 2),
              ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 3),
              $urandom_range(0, 2));
      run_frame(1, -1, ($urandom_range(0, 4) == 0) ? $urandom_range(1, 40) : -1, -1, 1'b1);
    end

    // Asynchronous reset in the middle of a frame that already flagged underflow
    set_cfg(3, 4, 3, 3, 2, 3);
    drive_pix(2, 33);
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    for (int i = 0; i < 40; i++) begin
      drive_pix(2, 33);
      tick();
    end
    check("pre_reset_busy", o_busy, 1);
    check("pre_reset_uf", o_underflow, 1);
    #2;
    rstn = 1'b0;
    #1;
    check_all_zero("async_reset");
    model_reset();
    @(posedge clk);
    #2;
    rstn = 1'b1;
    @(posedge clk);
    #1;
    repeat (3) tick();
    run_frame(0, -1, -1, -1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
